reg_writeback_arbiter: RTL and testbench

Drives the register file write port (RegWrite/WriteReg/WriteData) from two result sources:
- the single-cycle ALU path, which has no backpressure;
- a long-latency path (load/multiply/divide) with a valid/ready handshake, buffered in a small FIFO.

It also keeps a per-register pending-write scoreboard for hazard stalls, and provides same-cycle bypass for the write currently being committed. Writes to register 0 are dropped here, because the register file has no hardwired zero.

---
 rtl/reg_writeback_arbiter.sv | 178 +++++++++++++++++
 tb/tb_reg_writeback_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_writeback_arbiter.sv
// reg_writeback_arbiter
//   Drives the register file write port from two result sources: the single-cycle
//   ALU path (no backpressure) and a long-latency path (valid/ready) buffered in a
//   DEPTH-entry FIFO. Keeps a per-register pending-write scoreboard (Busy) and
//   offers same-cycle bypass of the write being committed. Writes to r0 are dropped.
//
// Optional feature: define WB_STARVE_GUARD_EN to add the STARVE_LIMIT parameter,
//   the AluStall output and a head-wait counter that forces the slow head through
//   after STARVE_LIMIT lost arbitrations.
//
// Ports:
//   Clk, Rst_n                 clock (rising edge), async active-low reset
//   AluValid/AluReg/AluData    ALU result
//   SlowValid/SlowReady        slow-path handshake (SlowReady = !full)
//   SlowReg/SlowData           slow-path result
//   IssueValid/IssueReg        long-latency op issued, marks IssueReg busy
//   Busy                       pending slow write per register
//   RegWrite/WriteReg/WriteData registered register file write port
//   ByReg1/2, ByHit1/2, ByData1/2  bypass of the write currently committing
//   AluStall                   (WB_STARVE_GUARD_EN only) ALU input ignored this cycle

module reg_writeback_arbiter #(
    parameter int unsigned DEPTH = 4
`ifdef WB_STARVE_GUARD_EN
    ,
    parameter int unsigned STARVE_LIMIT = 8
`endif
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        AluValid,
    input  logic [4:0]  AluReg,
    input  logic [31:0] AluData,
    input  logic        SlowValid,
    output logic        SlowReady,
    input  logic [4:0]  SlowReg,
    input  logic [31:0] SlowData,
    input  logic        IssueValid,
    input  logic [4:0]  IssueReg,
    output logic [31:0] Busy,
`ifdef WB_STARVE_GUARD_EN
    output logic        AluStall,
`endif
    output logic        RegWrite,
    output logic [4:0]  WriteReg,
    output logic [31:0] WriteData,
    input  logic [4:0]  ByReg1,
    input  logic [4:0]  ByReg2,
    output logic        ByHit1,
    output logic        ByHit2,
    output logic [31:0] ByData1,
    output logic [31:0] ByData2
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [4:0]    fifo_reg  [DEPTH];
    logic [31:0]   fifo_data [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;

    logic        full, empty, push, pop;
    logic        alu_cand, slow_cand, sel_alu, head_write;
    logic [4:0]  head_reg;
    logic [31:0] head_data;
    logic [31:0] busy_q, busy_d;
    logic        reg_write_q;
    logic [4:0]  write_reg_q;
    logic [31:0] write_data_q;

    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == '0);
    // Held low while in reset so no push can be accepted before the FIFO is live.
    assign SlowReady = Rst_n && !full;
    assign push      = SlowValid && SlowReady;
    assign head_reg  = fifo_reg[rd_ptr_q];
    assign head_data = fifo_data[rd_ptr_q];
    assign alu_cand  = AluValid && (AluReg != 5'd0);
    assign slow_cand = !empty;

`ifdef WB_STARVE_GUARD_EN
    localparam int unsigned WAIT_W = $clog2(STARVE_LIMIT + 1);

    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              starve;

    // Counter is only non-zero while the FIFO holds an entry.
    assign starve   = slow_cand && (wait_q == WAIT_W'(STARVE_LIMIT));
    assign AluStall = starve;
    assign sel_alu  = alu_cand && !starve;
    assign pop      = slow_cand && !sel_alu;

    always_comb begin
        wait_d = wait_q + WAIT_W'(1);
        if (!slow_cand || pop) begin
            wait_d = '0;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end
`else
    assign sel_alu = alu_cand;
    assign pop     = slow_cand && !alu_cand;
`endif

    // A popped r0 entry is discarded: no write and no scoreboard change.
    assign head_write = pop && (head_reg != 5'd0);

    always_comb begin
        busy_d = busy_q;
        if (head_write) begin
            busy_d[head_reg] = 1'b0;
        end
        // Applied after the clear so a same-edge re-issue keeps the bit set.
        if (IssueValid && (IssueReg != 5'd0)) begin
            busy_d[IssueReg] = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (push) begin
            fifo_reg[wr_ptr_q]  <= SlowReg;
            fifo_data[wr_ptr_q] <= SlowData;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            busy_q       <= '0;
            reg_write_q  <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
            busy_q      <= busy_d;
            reg_write_q <= sel_alu || head_write;
            // Address/data hold when nothing is written; RegWrite qualifies them.
            if (sel_alu) begin
                write_reg_q  <= AluReg;
                write_data_q <= AluData;
            end else if (head_write) begin
                write_reg_q  <= head_reg;
                write_data_q <= head_data;
            end
        end
    end

    assign Busy      = busy_q;
    assign RegWrite  = reg_write_q;
    assign WriteReg  = write_reg_q;
    assign WriteData = write_data_q;

    assign ByHit1  = reg_write_q && (write_reg_q == ByReg1) && (ByReg1 != 5'd0);
    assign ByHit2  = reg_write_q && (write_reg_q == ByReg2) && (ByReg2 != 5'd0);
    assign ByData1 = ByHit1 ? write_data_q : 32'd0;
    assign ByData2 = ByHit2 ? write_data_q : 32'd0;

endmodule

// File: tb/tb_reg_writeback_arbiter.sv
module tb_reg_writeback_arbiter;

    localparam int unsigned DEPTH = 4;
`ifdef WB_STARVE_GUARD_EN
    localparam int unsigned STARVE_LIMIT = 8;
    logic AluStall;
`endif

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b1;
    logic        AluValid = 1'b0;
    logic [4:0]  AluReg = '0;
    logic [31:0] AluData = '0;
    logic        SlowValid = 1'b0;
    logic        SlowReady;
    logic [4:0]  SlowReg = '0;
    logic [31:0] SlowData = '0;
    logic        IssueValid = 1'b0;
    logic [4:0]  IssueReg = '0;
    logic [31:0] Busy;
    logic        RegWrite;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic [4:0]  ByReg1 = '0;
    logic [4:0]  ByReg2 = '0;
    logic        ByHit1, ByHit2;
    logic [31:0] ByData1, ByData2;

    reg_writeback_arbiter #(
        .DEPTH(DEPTH)
    ) dut (
        .Clk(Clk),
        .Rst_n(Rst_n),
        .AluValid(AluValid),
        .AluReg(AluReg),
        .AluData(AluData),
        .SlowValid(SlowValid),
        .SlowReady(SlowReady),
        .SlowReg(SlowReg),
        .SlowData(SlowData),
        .IssueValid(IssueValid),
        .IssueReg(IssueReg),
        .Busy(Busy),
`ifdef WB_STARVE_GUARD_EN
        .AluStall(AluStall),
`endif
        .RegWrite(RegWrite),
        .WriteReg(WriteReg),
        .WriteData(WriteData),
        .ByReg1(ByReg1),
        .ByReg2(ByReg2),
        .ByHit1(ByHit1),
        .ByHit2(ByHit2),
        .ByData1(ByData1),
        .ByData2(ByData2)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic        v;
        logic [4:0]  r;
        logic [31:0] d;
    } wr_t;

    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    wr_t         exp_q[$];
    ent_t        m_fifo[$];
    logic [31:0] m_busy = '0;
    int          m_wait = 0;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Reference model: one expected write-port state per clock edge.
    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            exp_q.delete();
            m_fifo.delete();
            m_busy = '0;
            m_wait = 0;
        end else begin
            wr_t  w;
            ent_t h;
            ent_t n;
            logic alu_c, slow_c, stall, popm, ready_m, viol;
            alu_c   = AluValid && (AluReg != 5'd0);
            slow_c  = (m_fifo.size() != 0);
            ready_m = (m_fifo.size() < DEPTH);
            stall   = 1'b0;
`ifdef WB_STARVE_GUARD_EN
            stall = slow_c && (m_wait == STARVE_LIMIT);
`endif
            popm = slow_c && !(alu_c && !stall);
            viol = IssueValid && (IssueReg != 5'd0) && m_busy[IssueReg]
                   && !(popm && (m_fifo[0].r == IssueReg));
            assert (!viol) else begin
                errors++;
                $error("FAIL issue_to_busy reg=%0d", IssueReg);
            end
            w = '0;
            if (alu_c && !stall) begin
                w.v = 1'b1;
                w.r = AluReg;
                w.d = AluData;
            end else if (popm) begin
                h = m_fifo.pop_front();
                if (h.r != 5'd0) begin
                    w.v = 1'b1;
                    w.r = h.r;
                    w.d = h.d;
                    m_busy[h.r] = 1'b0;
                end
            end
            if (IssueValid && (IssueReg != 5'd0)) m_busy[IssueReg] = 1'b1;
            if (SlowValid && ready_m) begin
                n.r = SlowReg;
                n.d = SlowData;
                m_fifo.push_back(n);
            end
            m_wait = (!slow_c || popm) ? 0 : m_wait + 1;
            exp_q.push_back(w);
        end
    end

    // Monitor: compare every cycle against the model, away from the active edge.
    always @(negedge Clk) begin
        wr_t  w;
        logic hit1, hit2;
        if (Rst_n) begin
            if (exp_q.size() != 0) begin
                w = exp_q.pop_front();
                check("regwrite", RegWrite, w.v);
                if (w.v) begin
                    check("writereg", WriteReg, w.r);
                    check("writedata", WriteData, w.d);
                end
                hit1 = w.v && (w.r == ByReg1) && (ByReg1 != 5'd0);
                hit2 = w.v && (w.r == ByReg2) && (ByReg2 != 5'd0);
                check("byhit1", ByHit1, hit1);
                check("bydata1", ByData1, hit1 ? w.d : 32'd0);
                check("byhit2", ByHit2, hit2);
                check("bydata2", ByData2, hit2 ? w.d : 32'd0);
            end
            check("busy", Busy, m_busy);
            check("slowready", SlowReady, m_fifo.size() < DEPTH);
`ifdef WB_STARVE_GUARD_EN
            check("alustall", AluStall, (m_fifo.size() != 0) && (m_wait == STARVE_LIMIT));
`endif
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ready_pre;
        int   n;
        #1 Rst_n = 1'b0;
        #1;
        check("rst_regwrite", RegWrite, 1'b0);
        check("rst_writedata", WriteData, 32'd0);
        check("rst_busy", Busy, 32'd0);
        check("rst_slowready", SlowReady, 1'b0);
        repeat (2) @(negedge Clk);
        #2 Rst_n = 1'b1;
        tick();
        check("ready_after_rst", SlowReady, 1'b1);

        // ALU only, with bypass
        AluValid = 1'b1; AluReg = 5'd5; AluData = 32'h1234; ByReg1 = 5'd5; ByReg2 = 5'd6;
        tick();
        check("alu_regwrite", RegWrite, 1'b1);
        check("alu_writereg", WriteReg, 5'd5);
        check("alu_writedata", WriteData, 32'h1234);
        check("alu_byhit1", ByHit1, 1'b1);
        check("alu_bydata1", ByData1, 32'h1234);
        check("alu_byhit2", ByHit2, 1'b0);
        AluReg = 5'd0; AluData = 32'hdead;
        tick();
        check("alu_r0_regwrite", RegWrite, 1'b0);
        check("alu_r0_byhit1", ByHit1, 1'b0);
        AluValid = 1'b0; ByReg1 = 5'd7; ByReg2 = 5'd9;
        tick();

        // Collision: ALU 3, 4 ahead of slow 7
        IssueValid = 1'b1; IssueReg = 5'd7;
        tick();
        IssueValid = 1'b0;
        check("busy7_set", Busy[7], 1'b1);
        SlowValid = 1'b1; SlowReg = 5'd7; SlowData = 32'hAAAA;
        AluValid = 1'b1; AluReg = 5'd3; AluData = 32'h3333;
        tick();
        check("col_w3", WriteReg, 5'd3);
        SlowValid = 1'b0; AluReg = 5'd4; AluData = 32'h4444;
        tick();
        check("col_w4", WriteReg, 5'd4);
        check("busy7_held", Busy[7], 1'b1);
        AluValid = 1'b0;
        tick();
        check("col_w7", WriteReg, 5'd7);
        check("col_d7", WriteData, 32'hAAAA);
        check("busy7_clr", Busy[7], 1'b0);
        tick();

        // Full FIFO under continuous ALU traffic
        for (int i = 0; i < 5; i++) begin
            IssueValid = 1'b1; IssueReg = 5'(10 + i);
            tick();
        end
        IssueValid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            AluValid = 1'b1; AluReg = 5'(1 + i); AluData = 32'(32'hC000 + i);
            SlowValid = 1'b1; SlowReg = 5'(10 + i); SlowData = 32'(32'hB000 + i);
            tick();
        end
        check("full_ready0", SlowReady, 1'b0);
        SlowReg = 5'd14; SlowData = 32'hB00E; AluReg = 5'd2; AluData = 32'hC0C0;
        tick();
        check("full_held", SlowReady, 1'b0);
        AluValid = 1'b0;
        n = 0;
        do begin
            ready_pre = SlowReady;
            tick();
            n++;
        end while (!ready_pre && n < 20);
        check("push14_accepted", ready_pre, 1'b1);
        SlowValid = 1'b0;
        repeat (6) tick();

        // Scoreboard race and r0 discard
        IssueValid = 1'b1; IssueReg = 5'd9;
        tick();
        IssueValid = 1'b0; SlowValid = 1'b1; SlowReg = 5'd9; SlowData = 32'h9999;
        tick();
        SlowValid = 1'b0; IssueValid = 1'b1; IssueReg = 5'd9;
        tick();
        IssueValid = 1'b0;
        check("race_w9", WriteReg, 5'd9);
        check("race_busy9", Busy[9], 1'b1);
        SlowValid = 1'b1; SlowData = 32'h9A9A;
        tick();
        SlowValid = 1'b0;
        tick();
        check("race_busy9_clr", Busy[9], 1'b0);
        SlowValid = 1'b1; SlowReg = 5'd0; SlowData = 32'h0F0F;
        tick();
        SlowValid = 1'b0;
        tick();
        check("r0_pop_nowrite", RegWrite, 1'b0);
        tick();

`ifdef WB_STARVE_GUARD_EN
        // Starvation guard
        IssueValid = 1'b1; IssueReg = 5'd20;
        tick();
        IssueValid = 1'b0;
        SlowValid = 1'b1; SlowReg = 5'd20; SlowData = 32'h2020;
        AluValid = 1'b1; AluReg = 5'd1; AluData = 32'h0001;
        tick();
        SlowValid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check("starve_stall", AluStall, k == 8);
        end
        tick();
        check("starve_w20", WriteReg, 5'd20);
        check("starve_stall_off", AluStall, 1'b0);
        check("starve_busy20", Busy[20], 1'b0);
        AluValid = 1'b0;
        tick();
`endif

        // Reset mid-operation with a pending slow write
        IssueValid = 1'b1; IssueReg = 5'd25;
        AluValid = 1'b1; AluReg = 5'd6; AluData = 32'h6666;
        tick();
        IssueValid = 1'b0; SlowValid = 1'b1; SlowReg = 5'd25; SlowData = 32'h2525;
        tick();
        SlowValid = 1'b0;
        #2 Rst_n = 1'b0;
        #1;
        check("midrst_regwrite", RegWrite, 1'b0);
        check("midrst_busy", Busy, 32'd0);
        check("midrst_writedata", WriteData, 32'd0);
        check("midrst_slowready", SlowReady, 1'b0);
        AluValid = 1'b0;
        @(negedge Clk);
        #2 Rst_n = 1'b1;
        tick();
        check("midrst_ready", SlowReady, 1'b1);
        check("midrst_nowrite", RegWrite, 1'b0);
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
